// File: rtl/transmit.sv
// Two-entry skid buffer between a producer and the downstream receive stage.
// All handshake outputs are decoded from registers, so no input reaches an output combinationally.
module transmit #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  input  logic          out_ready,
  output logic [CW-1:0] sent_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [N-1:0] main_q, main_nxt;
  logic [N-1:0] skid_q, skid_nxt;
  logic         in_fire, out_fire;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      sent_cnt <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
      if (out_fire)
        sent_cnt <= sent_cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          main_nxt  = in_data;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_nxt = in_data;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end else if (in_fire) begin
          skid_nxt  = in_data;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_nxt  = skid_q;
          state_nxt = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush drops any word accepted this cycle; the output transfer is still counted above.
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
    end
  end

endmodule

// File: doc/transmit.md
TRANSMIT -- requirements
Module: transmit

Interface
REQ-001 Parameter N, default 32, is the data word width in bits.
REQ-002 Parameter CW, default 16, is the width of the sent-word counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-004 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-006 Port in_valid SHALL be an input, 1 bit wide: the producer offers in_data.
REQ-007 Port in_data SHALL be an input, N bits wide: the word offered by the producer.
REQ-008 Port in_ready SHALL be an output, 1 bit wide: the block can accept a word this cycle.
REQ-009 Port flush SHALL be an input, 1 bit wide: synchronous discard of all buffered words.
REQ-010 Port out_valid SHALL be an output, 1 bit wide: out_data holds a valid word.
REQ-011 Port out_data SHALL be an output, N bits wide: the word presented to the downstream receive stage.
REQ-012 Port out_ready SHALL be an input, 1 bit wide: downstream accepts out_data this cycle.
REQ-013 Port sent_cnt SHALL be an output, CW bits wide: count of completed output transfers.

Function
REQ-014 An input fire SHALL be in_valid&in_ready; an output fire SHALL be out_valid&out_ready.
REQ-015 The block SHALL hold two N-bit registers, main and skid, and a 2-bit state register with states EMPTY, BUSY (main valid) and FULL (main and skid valid).
REQ-016 out_valid SHALL equal (state!=EMPTY), out_data SHALL equal main, and in_ready SHALL equal (state!=FULL), all decoded from registers only, with no combinational path from in_* or out_ready.
REQ-017 In EMPTY, an input fire SHALL load main and go to BUSY.
REQ-018 In BUSY, an input fire together with an output fire SHALL load main from in_data and stay in BUSY.
REQ-019 In BUSY, an output fire alone SHALL go to EMPTY.
REQ-020 In BUSY, an input fire alone SHALL load skid and go to FULL.
REQ-021 In FULL, an output fire SHALL copy skid into main and go to BUSY; no input is accepted in FULL.
REQ-022 Latency SHALL be one cycle: a word accepted in cycle k SHALL appear on out_data no earlier than cycle k+1.
REQ-023 Words SHALL leave in acceptance order with none lost or duplicated.
REQ-024 While out_valid=1 and out_ready=0, out_data SHALL stay stable.
REQ-025 flush=1 SHALL force the next state to EMPTY regardless of other inputs, and any input fire in that cycle SHALL be discarded.
REQ-026 An output fire in a flush cycle SHALL still count as transferred.
REQ-027 sent_cnt SHALL increment by 1 on every output fire, wrapping from 2^CW-1 to 0.
REQ-028 flush SHALL NOT clear sent_cnt.
REQ-029 Register contents SHALL be unchanged when no fire occurs.

Reset
REQ-030 While rst_n=0, state SHALL be EMPTY, main=0, skid=0 and sent_cnt=0, so out_valid=0, out_data=0 and in_ready=1.
REQ-031 Assertion of rst_n mid-transfer SHALL discard buffered words immediately, without waiting for a clock.
REQ-032 Inputs SHALL be ignored until the first rising clk edge after rst_n deasserts.

Verification
REQ-033 Reset then in_valid=1, in_data=0xA5A5A5A5, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=0xA5A5A5A5, and sent_cnt=1 a cycle later.
REQ-034 out_ready=0, push 0x1 then 0x2 -> in_ready=0 after the second push; then out_ready=1 -> outputs 0x1 then 0x2 on consecutive cycles, then in_ready=1.
REQ-035 FULL state plus flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the input word is never output, and sent_cnt is unchanged.
REQ-036 Preload sent_cnt to 0xFFFF via 65535 transfers, then one more transfer -> sent_cnt=0x0000.
REQ-037 Randomized in_valid/out_ready for 10k cycles -> output sequence equals input sequence, and out_data is stable whenever it is stalled.
REQ-038 rst_n pulsed low asynchronously in FULL -> out_valid=0 and sent_cnt=0 immediately, and the skid word is never output.
